rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Writeback-side driver of the register file's single write port: merges the in-order pipeline writeback stream with results from long-latency units (multiply/divide, late loads) into at most one register write per cycle. Pipeline writebacks have absolute priority. Long-latency results are buffered in a small FIFO and drained in idle write slots. An optional scoreboard tracks destination registers with outstanding long-latency results so that decode can stall on RAW/WAW hazards.

## Interface
Parameters:
- DEPTH, 4 — long-latency result FIFO entries; power of 2, ≥2
- MAX_WAIT, 8 — consecutive starved cycles before a pipeline stall is requested; ≥1

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  pipeline writeback valid; never back-pressured
- a_waddr  in  5  pipeline destination register
- a_wdata  in  32  pipeline result
- b_valid  in  1  long-latency result valid
- b_ready  out  1  FIFO can accept; equals !full
- b_waddr  in  5  long-latency destination register
- b_wdata  in  32  long-latency result
- iss_valid  in  1  long-latency op issued (scoreboard set)
- iss_waddr  in  5  destination of issued op
- busy  out  32  per-register pending mask; bit 0 always 0
- stall_req  out  1  pipeline must present a_valid=0 this cycle
- we  out  1  register file write enable
- waddr  out  5  register file write address
- wdata  out  32  register file write data

## Operation
- B accept: b_valid && b_ready at a posedge pushes {b_waddr, b_wdata}. An entry becomes eligible for write no earlier than the next cycle.
- Port select (combinational):
  - If a_valid, drive A.
  - Else if FIFO is non-empty, drive the FIFO head and pop it at the posedge.
  - Else, we=0.
- Register 0: any selection with address 0 forces we=0. A FIFO head with address 0 is still popped.
- Full FIFO: b_ready=0. Simultaneous pop and push is allowed when full only via the next cycle's b_ready; b_ready never depends combinationally on the pop.
- Starvation counter wait_cnt, with 0..MAX_WAIT saturating:
  - Increments on each posedge where the FIFO is non-empty and a_valid=1.
  - Clears on any pop or when the FIFO is empty.
  - stall_req = (wait_cnt == MAX_WAIT).
  - a_valid=1 while stall_req=1 is a protocol error; A still wins the port and the counter stays saturated.
- Ordering: the issue scoreboard keeps WAW between A and pending B entries from arising. B entries drain strictly in FIFO order.
- Reset mid-operation: the FIFO is emptied and buffered results are discarded. Upstream units are flushed by the same reset.

## Timing
- A path: zero latency, combinational a_* → we/waddr/wdata, written at the same posedge.
- B path: minimum 1 cycle from accept to write. Worst case is bounded by MAX_WAIT+1 cycles per entry ahead of it plus its own slot.
- Reset values (during and after rst, until first push): b_ready=1, we=0, waddr=0, wdata=0, busy=0, stall_req=0, wait_cnt=0, FIFO empty.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and low bits equal; empty = pointers equal.

## Configuration
- RF_WB_SCOREBOARD_EN defined:
  - busy[r] sets at a posedge with iss_valid && iss_waddr==r && r!=0.
  - busy[r] clears at a posedge where the FIFO head with address r is popped.
  - Set and clear of the same register in the same cycle: set wins.
- Not defined: busy tied to 0 and iss_* ignored. Decode must then stall on any outstanding long-latency op by other means.

## Structure
- Package rf_wb_pkg: REG_AW=5, DATA_W=32, NREG=32, typedef wb_entry_t {logic [4:0] waddr; logic [31:0] wdata;}.
- Sub-module rf_wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/head. Arbitration, starvation counter and scoreboard live in the top.

## Test plan
- Reset then idle: rst=1 for 2 cycles → we=0, busy=0, b_ready=1, stall_req=0.
- B only: push {r5, 0xDEADBEEF} with a_valid=0 → next cycle we=1, waddr=5, wdata=0xDEADBEEF; then FIFO empty and busy[5] cleared (EN).
- Collision: same cycle a_valid {r3,0x11}, b push {r7,0x22} → cycle 0 writes r3; cycle 1 writes r7 if a_valid=0.
- Fill: 4 B pushes with a_valid held 1 → b_ready=0 after 4th push; after MAX_WAIT=8 starved cycles stall_req=1; drop a_valid → r-writes drain in push order.
- Reg 0: A {r0,0xFF} and B {r0,0xAA} → we never 1; B entry popped, FIFO empty.
- Scoreboard (EN): iss r9 and pop of r9 in same cycle → busy[9]=1 afterward. Mid-drain rst → FIFO empty, busy=0 next cycle.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared widths and the writeback payload type for the register-file write arbiter.
package rf_wb_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of writeback entries; pointers carry one extra wrap bit.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full_c,
  output logic      empty_c,
  output wb_entry_t head_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full_c;
  assign do_pop  = pop && !empty_c;

  assign full_c  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign empty_c = (wr_ptr == rd_ptr);
  assign head_c  = mem[rd_ptr[IDX_W-1:0]];

  // Pointer update; reset discards every buffered entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage write; contents need no reset since empty_c masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks win, long-latency
// results queue in a FIFO and drain in idle slots.
// Optional scoreboard enabled by defining RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [REG_AW-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [REG_AW-1:0] b_waddr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_waddr,
  output logic [NREG-1:0]   busy,
  output logic              stall_req,
  output logic              we,
  output logic [REG_AW-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  wb_entry_t         push_entry;
  wb_entry_t         head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              sel_a;
  logic              sel_b;
  logic [WAIT_W-1:0] wait_cnt;

  assign push_entry.waddr = b_waddr;
  assign push_entry.wdata = b_wdata;

  assign b_ready = !full;
  assign push    = b_valid && b_ready;
  assign sel_a   = a_valid && !rst;
  assign sel_b   = !a_valid && !empty && !rst;
  assign pop     = sel_b;

  assign stall_req = (wait_cnt == WAIT_W'(MAX_WAIT));

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (push_entry),
    .full_c  (full),
    .empty_c (empty),
    .head_c  (head)
  );

  // Write-port mux; register 0 is never written.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (sel_a) begin
      we    = (a_waddr != '0);
      waddr = a_waddr;
      wdata = a_wdata;
    end else if (sel_b) begin
      we    = (head.waddr != '0);
      waddr = head.waddr;
      wdata = head.wdata;
    end
  end

  // Starvation counter: counts cycles where queued results lose to the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (pop || empty) begin
      wait_cnt <= '0;
    end else if (a_valid && !stall_req) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Per-register set/clear requests for this cycle; issue beats retire.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid) set_mask[iss_waddr] = 1'b1;
    if (pop)       clr_mask[head.waddr] = 1'b1;
    set_mask[0] = 1'b0;
  end

  // Pending-destination scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  assign busy = busy_q;
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_waddr};
  assign busy       = '0;
`endif

endmodule
